// File: rtl/vector_serializer_pkg.sv
// Shared types for the vector serializer: the two-state sender FSM encoding.
package vector_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/vs_next_index.sv
// Finds the lowest set bit of mask_i strictly above idx_i; none_left_o flags that none remains.
module vs_next_index #(
  parameter int N = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] idx_i,
  output logic [IW-1:0] next_idx_o,
  output logic          none_left_o
);

  // Scanning downward lets the lowest qualifying position overwrite the others.
  always_comb begin
    next_idx_o  = '0;
    none_left_o = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(idx_i))) begin
        next_idx_o  = IW'(i);
        none_left_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vector_serializer.sv
// Accepts an N-element vector and streams its elements out one per cycle with their indices.
// Optional SERIALIZER_SKIP_ZERO_EN: emit only nonzero elements; all-zero vectors are dropped.
module vector_serializer
  import vector_serializer_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  localparam int IW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] vector [N-1:0],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IW-1:0]         out_index,
  output logic                  out_last
);

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] buffer_q [N-1:0];
  logic                  load;
  logic                  accept;
  logic                  last_beat;
  logic [IW-1:0]         first_idx;
  logic [IW-1:0]         step_idx;
  logic                  vec_nonempty;

`ifdef SERIALIZER_SKIP_ZERO_EN
  logic [N-1:0] new_mask;
  logic [N-1:0] mask_q;
  logic         none_left;

  always_comb begin
    new_mask  = '0;
    first_idx = '0;
    for (int i = 0; i < N; i++) begin
      new_mask[i] = |vector[i];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (new_mask[i]) first_idx = IW'(i);
    end
  end

  assign vec_nonempty = |new_mask;
  assign last_beat    = none_left;

  vs_next_index #(.N(N)) u_next_index (
    .mask_i      (mask_q),
    .idx_i       (idx_q),
    .next_idx_o  (step_idx),
    .none_left_o (none_left)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
    end else if (load) begin
      mask_q <= new_mask;
    end
  end
`else
  assign first_idx    = '0;
  assign vec_nonempty = 1'b1;
  assign step_idx     = idx_q + IW'(1);
  assign last_beat    = (idx_q == IW'(N - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < N; i++) begin
        buffer_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        buffer_q <= vector;
      end
    end
  end

  assign accept = in_valid & in_ready;

  // A new vector can be taken either from IDLE or on the final beat of the current one.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          idx_d   = first_idx;
          state_d = vec_nonempty ? SEND : IDLE;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_beat) begin
            if (accept) begin
              load    = 1'b1;
              idx_d   = first_idx;
              state_d = vec_nonempty ? SEND : IDLE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = step_idx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      SEND: begin
        out_valid = 1'b1;
        out_data  = buffer_q[idx_q];
        out_index = idx_q;
        out_last  = last_beat;
        in_ready  = out_ready & last_beat;
      end
      default: in_ready = 1'b0;
    endcase
  end

endmodule
